// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative MIPS mult/multu/div/divu with HI/LO registers; MDU_FAST_MUL_EN selects a single-cycle multiply
module mul_div_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [1:0]        op_i,
  input  logic [DATA_W-1:0] rs_val_i,
  input  logic [DATA_W-1:0] rt_val_i,
  input  logic              hi_we_i,
  input  logic              lo_we_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);
  typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;
`ifdef MDU_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  state_t state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic div_q, div_d, neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d, done_q, done_d;
  logic [31:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic [63:0] acc_q, acc_d, mag, prod;
  logic sgn, is_div, dz;
  logic [31:0] rs_abs, rt_abs, quo, rem;
  logic [32:0] msum, rsh;
  logic [33:0] diff;
  assign sgn    = ~op_i[0];
  assign is_div = op_i[1];
  assign dz     = is_div && rt_val_i == 32'd0;
  assign rs_abs = sgn && rs_val_i[31] ? -rs_val_i : rs_val_i;
  assign rt_abs = sgn && rt_val_i[31] ? -rt_val_i : rt_val_i;
  assign msum   = {1'b0, acc_q[63:32]} + (b_q[0] ? {1'b0, a_q} : 33'd0);
  assign rsh    = {acc_q[31:0], b_q[31]};
  assign diff   = {1'b0, rsh} - {2'b0, a_q};
`ifdef MDU_FAST_MUL_EN
  assign mag    = {32'd0, a_q} * {32'd0, b_q};
`else
  assign mag    = acc_q;
`endif
  assign prod   = neg_q ? -mag : mag;
  assign quo    = neg_q ? -b_q : b_q;
  assign rem    = rneg_q ? -acc_q[31:0] : acc_q[31:0];
  assign busy_o = state_q != IDLE;
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;
  // next state: operand capture, one shift-add or restore-subtract step per ITER cycle, sign fix and HI/LO write in FIX
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    if (state_q == IDLE) begin
      if (start_i) begin
        div_d   = is_div;
        neg_d   = sgn & (rs_val_i[31] ^ rt_val_i[31]);
        rneg_d  = sgn & rs_val_i[31];
        dz_d    = dz;
        a_d     = is_div ? rt_abs : rs_abs;
        b_d     = dz ? rs_val_i : is_div ? rs_abs : rt_abs;
        acc_d   = 64'd0;
        cnt_d   = 5'd0;
        state_d = dz || (FAST && !is_div) ? FIX : ITER;
      end else begin
        hi_d = hi_we_i ? wdata_i : hi_q;
        lo_d = lo_we_i ? wdata_i : lo_q;
      end
    end else if (state_q == ITER) begin
      cnt_d   = cnt_q + 5'd1;
      acc_d   = div_q ? {31'd0, diff[33] ? rsh : diff[32:0]} : {msum, acc_q[31:1]};
      b_d     = div_q ? {b_q[30:0], ~diff[33]} : b_q >> 1;
      state_d = cnt_q == 5'd31 ? FIX : ITER;
    end else begin
      hi_d    = div_q ? (dz_q ? b_q : rem) : prod[63:32];
      lo_d    = div_q ? (dz_q ? 32'hFFFF_FFFF : quo) : prod[31:0];
      done_d  = 1'b1;
      state_d = IDLE;
    end
  end
  // state and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      acc_q   <= 64'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: scoreboard bench for mul_div_unit with directed vectors
module tb_mul_div_unit;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
  logic [1:0] op = 2'b00;
  logic [31:0] rs = 32'd0, rt = 32'd0, wdata = 32'd0;
  logic busy, done;
  logic [31:0] hi, lo;
  int cyc = 0, total = 0, passed = 0, ndone = 0, n0 = 0, d0 = 0;
`ifdef MDU_FAST_MUL_EN
  localparam int LM = 2;
`else
  localparam int LM = 34;
`endif
  typedef struct {int id; logic [31:0] hi; logic [31:0] lo; int due;} exp_t;
  exp_t sb[$];
  exp_t e;
  mul_div_unit dut (
    .clk(clk), .rst(rst), .start_i(start), .op_i(op), .rs_val_i(rs), .rt_val_i(rt),
    .hi_we_i(hi_we), .lo_we_i(lo_we), .wdata_i(wdata),
    .busy_o(busy), .done_o(done), .hi_o(hi), .lo_o(lo)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask
  always @(negedge clk) begin
    if (done) begin
      ndone++;
      chk("pending_op_at_done", {31'd0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk($sformatf("op%0d_hi", e.id), hi, e.hi);
        chk($sformatf("op%0d_lo", e.id), lo, e.lo);
        chk($sformatf("op%0d_done_cycle", e.id), cyc, e.due);
      end
    end
  end
  task automatic drain(input int id);
    for (int i = 0; i < 80 && sb.size() != 0; i++) @(negedge clk);
    chk($sformatf("op%0d_timeout", id), sb.size(), 32'd0);
    sb.delete();
  endtask
  task automatic run(input int id, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] eh, input logic [31:0] el, input int lat, input logic w);
    @(negedge clk);
    start = 1'b1; op = o; rs = a; rt = b; hi_we = w; wdata = 32'hDEAD;
    sb.push_back('{id, eh, el, cyc + lat});
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0;
    drain(id);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    run(1, 2'b00, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, LM, 1'b0);
    run(2, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, LM, 1'b0);
    run(3, 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34, 1'b0);
    run(4, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 34, 1'b0);
    run(5, 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 34, 1'b0);
    run(6, 2'b11, 32'h1234, 32'd0, 32'h1234, 32'hFFFF_FFFF, 2, 1'b0);
    @(negedge clk);
    start = 1'b1; op = 2'b11; rs = 32'd100; rt = 32'd7; n0 = cyc;
    sb.push_back('{7, 32'd2, 32'd14, cyc + 34});
    @(negedge clk);
    start = 1'b0;
    while (cyc < n0 + 5) @(negedge clk);
    start = 1'b1; op = 2'b00; rs = 32'd3; rt = 32'd3; hi_we = 1'b1; wdata = 32'hAAAA;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0;
    chk("busy_in_flight", {31'd0, busy}, 32'd1);
    chk("hi_held_in_flight", hi, 32'h1234);
    chk("lo_held_in_flight", lo, 32'hFFFF_FFFF);
    drain(7);
    @(negedge clk);
    start = 1'b1; op = 2'b11; rs = 32'd100; rt = 32'd7; n0 = cyc; d0 = ndone;
    @(negedge clk);
    start = 1'b0;
    while (cyc < n0 + 10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    repeat (40) @(negedge clk);
    chk("abort_no_done", ndone, d0);
    lo_we = 1'b1; wdata = 32'h55;
    @(negedge clk);
    lo_we = 1'b0;
    chk("mtlo_lo", lo, 32'h55);
    chk("mtlo_hi_untouched", hi, 32'd0);
    hi_we = 1'b1; wdata = 32'h77;
    @(negedge clk);
    hi_we = 1'b0;
    chk("mthi_hi", hi, 32'h77);
    run(8, 2'b01, 32'd2, 32'd3, 32'd0, 32'd6, LM, 1'b1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
